// File: rtl/blake2_block_ctrl.sv
// BLAKE2s block controller: counts incoming message bytes per block, tracks
// the running byte offset t, kicks the compression core once per block and
// streams the digest out of the hash memory after the final block.
module blake2_block_ctrl #(
   parameter int BLOCK_BYTES    = 64,
   parameter int HASH_BYTES_MAX = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [5:0]                        kk_i,
   input  logic [5:0]                        nn_i,
   input  logic [63:0]                       ll_i,
   input  logic                              data_v_i,
   input  logic [$clog2(BLOCK_BYTES)-1:0]    data_idx_i,
   input  logic                              block_first_i,
   input  logic                              block_last_i,
   output logic                              cmp_start_o,
   output logic                              cmp_first_o,
   output logic                              cmp_last_o,
   output logic [63:0]                       cmp_t_o,
   input  logic                              cmp_done_i,
   output logic                              hash_rd_o,
   output logic [$clog2(HASH_BYTES_MAX)-1:0] hash_idx_o,
   output logic                              hash_v_o,
   output logic                              ready_v_o,
   output logic                              err_o
);

   localparam int IDX_W = $clog2(BLOCK_BYTES);
   localparam int HID_W = $clog2(HASH_BYTES_MAX);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BLOCK_BYTES - 1);
   localparam logic [63:0]      BLOCK_T    = 64'(BLOCK_BYTES);
   localparam logic [5:0]       N_MAX      = 6'(HASH_BYTES_MAX);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_START = 3'd2,
      ST_BUSY  = 3'd3,
      ST_OUT   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [63:0]        t_q, t_d;
   logic               first_q, first_d;
   logic               last_q, last_d;
   logic               err_q, err_d;
   logic [IDX_W-1:0]   prev_idx_q, prev_idx_d;
   logic [5:0]         n_q, n_d;
   logic [HID_W-1:0]   rd_cnt_q, rd_cnt_d;
   logic               hash_v_q;

   logic               accepting;
   logic               hash_rd;
   logic [IDX_W-1:0]   idx_expected;
   logic [63:0]        t_base;

   assign accepting    = (state_q == ST_IDLE) || (state_q == ST_FILL);
   assign hash_rd      = (state_q == ST_OUT) && (n_q != 6'd0);
   // After the last byte of a block prev_idx is 63, so the expectation wraps to 0.
   assign idx_expected = prev_idx_q + IDX_W'(1);
   assign t_base       = block_first_i ? 64'd0 : t_q;

   // State and datapath registers; reset abandons any block or readout in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         t_q        <= 64'd0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
         err_q      <= 1'b0;
         prev_idx_q <= '0;
         n_q        <= 6'd0;
         rd_cnt_q   <= '0;
         hash_v_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         t_q        <= t_d;
         first_q    <= first_d;
         last_q     <= last_d;
         err_q      <= err_d;
         prev_idx_q <= prev_idx_d;
         n_q        <= n_d;
         rd_cnt_q   <= rd_cnt_d;
         hash_v_q   <= hash_rd;
      end
   end

   // Next-state logic: byte counting, t update, core handshake and readout count.
   always_comb begin
      state_d    = state_q;
      t_d        = t_q;
      first_d    = first_q;
      last_d     = last_q;
      err_d      = err_q;
      prev_idx_d = prev_idx_q;
      n_d        = n_q;
      rd_cnt_d   = rd_cnt_q;

      // Bytes offered while we cannot take them, and stray done pulses, are dropped.
      if (data_v_i && !accepting) err_d = 1'b1;
      if (cmp_done_i && (state_q != ST_BUSY)) err_d = 1'b1;

      case (state_q)
         ST_IDLE, ST_FILL: begin
            if (data_v_i) begin
               if ((state_q == ST_FILL) && (data_idx_i != idx_expected)) err_d = 1'b1;
               prev_idx_d = data_idx_i;
               if (data_idx_i == IDX_LAST) begin
                  first_d = block_first_i;
                  last_d  = block_last_i;
                  // A keyed message carries one extra (key) block in front of the data.
                  if (block_last_i) t_d = ll_i + ((kk_i != 6'd0) ? BLOCK_T : 64'd0);
                  else              t_d = t_base + BLOCK_T;
                  state_d = ST_START;
               end else if ((state_q == ST_IDLE) && (data_idx_i == '0)) begin
                  state_d = ST_FILL;
               end
            end
         end
         ST_START: begin
            state_d = ST_BUSY;
         end
         ST_BUSY: begin
            if (cmp_done_i) begin
               if (last_q) begin
                  state_d  = ST_OUT;
                  n_d      = (nn_i > N_MAX) ? N_MAX : nn_i;
                  rd_cnt_d = '0;
               end else begin
                  state_d    = ST_FILL;
                  prev_idx_d = IDX_LAST;
               end
            end
         end
         ST_OUT: begin
            if (n_q == 6'd0) begin
               state_d = ST_IDLE;
               t_d     = 64'd0;
            end else begin
               rd_cnt_d = rd_cnt_q + HID_W'(1);
               if ({1'b0, rd_cnt_q} == (n_q - 6'd1)) begin
                  state_d = ST_IDLE;
                  t_d     = 64'd0;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from the current state and held block qualifiers.
   always_comb begin
      cmp_start_o = (state_q == ST_START);
      cmp_first_o = ((state_q == ST_START) || (state_q == ST_BUSY)) && first_q;
      cmp_last_o  = ((state_q == ST_START) || (state_q == ST_BUSY)) && last_q;
      cmp_t_o     = t_q;
      hash_rd_o   = hash_rd;
      hash_idx_o  = hash_rd ? rd_cnt_q : '0;
      hash_v_o    = hash_v_q;
      ready_v_o   = accepting;
      err_o       = err_q;
   end

endmodule

// File: tb/tb_blake2_block_ctrl.sv
// Directed bench for blake2_block_ctrl: single, multi-block, keyed, digest
// length, protocol error and mid-operation reset scenarios.
module tb_blake2_block_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  kk_i, nn_i;
   logic [63:0] ll_i;
   logic        data_v_i;
   logic [5:0]  data_idx_i;
   logic        block_first_i, block_last_i;
   logic        cmp_start_o, cmp_first_o, cmp_last_o;
   logic [63:0] cmp_t_o;
   logic        cmp_done_i;
   logic        hash_rd_o;
   logic [4:0]  hash_idx_o;
   logic        hash_v_o, ready_v_o, err_o;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   blake2_block_ctrl dut (
      .clk           (clk),
      .reset         (reset),
      .kk_i          (kk_i),
      .nn_i          (nn_i),
      .ll_i          (ll_i),
      .data_v_i      (data_v_i),
      .data_idx_i    (data_idx_i),
      .block_first_i (block_first_i),
      .block_last_i  (block_last_i),
      .cmp_start_o   (cmp_start_o),
      .cmp_first_o   (cmp_first_o),
      .cmp_last_o    (cmp_last_o),
      .cmp_t_o       (cmp_t_o),
      .cmp_done_i    (cmp_done_i),
      .hash_rd_o     (hash_rd_o),
      .hash_idx_o    (hash_idx_o),
      .hash_v_o      (hash_v_o),
      .ready_v_o     (ready_v_o),
      .err_o         (err_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present bytes lo..hi on consecutive cycles; returns at the cycle after the last byte.
   task automatic send_bytes(input int lo, input int hi, input logic f, input logic l);
      for (int i = lo; i <= hi; i++) begin
         @(negedge clk);
         data_v_i      = 1'b1;
         data_idx_i    = 6'(i);
         block_first_i = f;
         block_last_i  = l;
      end
      @(negedge clk);
      data_v_i = 1'b0;
   endtask

   // Full block: check the START cycle, the held BUSY outputs, then pulse done after 10 cycles.
   task automatic run_block(input string tag, input logic f, input logic l, input logic [63:0] exp_t);
      send_bytes(0, 63, f, l);
      $display("block %s first=%0b last=%0b start=%0b t=%0d", tag, cmp_first_o, cmp_last_o, cmp_start_o, cmp_t_o);
      check({tag, "_start"}, cmp_start_o, 1'b1);
      check({tag, "_first"}, cmp_first_o, f);
      check({tag, "_last"},  cmp_last_o, l);
      check({tag, "_t"},     cmp_t_o, exp_t);
      check({tag, "_rdy_start"}, ready_v_o, 1'b0);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check({tag, "_start_pulse"}, cmp_start_o, 1'b0);
            check({tag, "_busy_rdy"}, ready_v_o, 1'b0);
         end
      end
      check({tag, "_busy_t"}, cmp_t_o, exp_t);
      check({tag, "_busy_first"}, cmp_first_o, f);
      check({tag, "_busy_last"}, cmp_last_o, l);
      @(negedge clk);
      cmp_done_i = 1'b1;
      @(negedge clk);
      cmp_done_i = 1'b0;
      if (!l) check({tag, "_rdy_after_done"}, ready_v_o, 1'b1);
   endtask

   // Digest readout starting at the first OUT cycle; n is the expected read count.
   task automatic read_hash(input string tag, input int n);
      if (n == 0) begin
         check({tag, "_n0_rd"}, hash_rd_o, 1'b0);
         check({tag, "_n0_rdy"}, ready_v_o, 1'b0);
         check({tag, "_n0_v"}, hash_v_o, 1'b0);
         @(negedge clk);
      end
      for (int j = 0; j < n; j++) begin
         check({tag, "_rd"}, hash_rd_o, 1'b1);
         check({tag, "_idx"}, hash_idx_o, 64'(j));
         check({tag, "_v"}, hash_v_o, (j != 0));
         check({tag, "_rdy_out"}, ready_v_o, 1'b0);
         @(negedge clk);
      end
      $display("readout %s reads=%0d rd=%0b rdy=%0b t=%0d", tag, n, hash_rd_o, ready_v_o, cmp_t_o);
      check({tag, "_end_rd"}, hash_rd_o, 1'b0);
      check({tag, "_end_rdy"}, ready_v_o, 1'b1);
      check({tag, "_end_v"}, hash_v_o, (n != 0));
      check({tag, "_end_t"}, cmp_t_o, 64'd0);
      @(negedge clk);
      check({tag, "_v_drop"}, hash_v_o, 1'b0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      $display("reset %s rdy=%0b rd=%0b t=%0d err=%0b", tag, ready_v_o, hash_rd_o, cmp_t_o, err_o);
      check({tag, "_rdy"}, ready_v_o, 1'b1);
      check({tag, "_rd"}, hash_rd_o, 1'b0);
      check({tag, "_start"}, cmp_start_o, 1'b0);
      check({tag, "_t"}, cmp_t_o, 64'd0);
      check({tag, "_err"}, err_o, 1'b0);
      check({tag, "_v"}, hash_v_o, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; kk_i = '0; nn_i = '0; ll_i = '0;
      data_v_i = 1'b0; data_idx_i = '0; block_first_i = 1'b0; block_last_i = 1'b0;
      cmp_done_i = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdy", ready_v_o, 1'b1);
      check("rst_start", cmp_start_o, 1'b0);
      check("rst_t", cmp_t_o, 64'd0);
      check("rst_err", err_o, 1'b0);
      check("rst_rd", hash_rd_o, 1'b0);
      reset = 1'b0;

      // Single block, ll=3.
      kk_i = 6'd0; nn_i = 6'd32; ll_i = 64'd3;
      run_block("single", 1'b1, 1'b1, 64'd3);
      read_hash("single", 32);

      // Three blocks, ll=150, nn=40 clamps to 32 reads.
      kk_i = 6'd0; nn_i = 6'd40; ll_i = 64'd150;
      run_block("three0", 1'b1, 1'b0, 64'd64);
      run_block("three1", 1'b0, 1'b0, 64'd128);
      run_block("three2", 1'b0, 1'b1, 64'd150);
      read_hash("three", 32);

      // Key-only message, nn=0: no reads.
      kk_i = 6'd16; nn_i = 6'd0; ll_i = 64'd0;
      run_block("keyonly", 1'b1, 1'b1, 64'd64);
      read_hash("keyonly", 0);

      // Keyed with ll=100.
      kk_i = 6'd16; nn_i = 6'd8; ll_i = 64'd100;
      run_block("keyed0", 1'b1, 1'b0, 64'd64);
      run_block("keyed1", 1'b0, 1'b0, 64'd128);
      ll_i = 64'd100;
      run_block("keyed2", 1'b0, 1'b1, 64'd164);
      read_hash("keyed", 8);
      check("no_err_so_far", err_o, 1'b0);

      // Byte during BUSY is an error and changes nothing.
      kk_i = 6'd0; nn_i = 6'd4; ll_i = 64'd3;
      send_bytes(0, 63, 1'b1, 1'b1);
      check("busyerr_start", cmp_start_o, 1'b1);
      @(negedge clk);
      data_v_i = 1'b1; data_idx_i = 6'd0;
      @(negedge clk);
      data_v_i = 1'b0;
      $display("busy byte err=%0b start=%0b t=%0d", err_o, cmp_start_o, cmp_t_o);
      check("busyerr_err", err_o, 1'b1);
      check("busyerr_start2", cmp_start_o, 1'b0);
      check("busyerr_t", cmp_t_o, 64'd3);
      check("busyerr_rdy", ready_v_o, 1'b0);
      cmp_done_i = 1'b1;
      @(negedge clk);
      cmp_done_i = 1'b0;
      read_hash("busyerr", 4);
      do_reset("clr_err");

      // Index jump 5 -> 7 in FILL.
      send_bytes(0, 5, 1'b1, 1'b0);
      check("jump_before", err_o, 1'b0);
      send_bytes(7, 7, 1'b1, 1'b0);
      $display("index jump err=%0b rdy=%0b", err_o, ready_v_o);
      check("jump_err", err_o, 1'b1);
      check("jump_rdy", ready_v_o, 1'b1);
      do_reset("after_jump");

      // Reset during BUSY.
      kk_i = 6'd0; nn_i = 6'd32; ll_i = 64'd3;
      send_bytes(0, 63, 1'b1, 1'b1);
      @(negedge clk);
      check("rstbusy_rdy_pre", ready_v_o, 1'b0);
      do_reset("rst_busy");
      @(negedge clk);
      check("rstbusy_nostart", cmp_start_o, 1'b0);

      // Reset during OUT at idx 10.
      run_block("preout", 1'b1, 1'b1, 64'd3);
      for (int j = 0; j < 10; j++) @(negedge clk);
      check("rstout_idx", hash_idx_o, 64'd10);
      do_reset("rst_out");
      @(negedge clk);
      check("rstout_rd_after", hash_rd_o, 1'b0);

      // Clean message after resets.
      kk_i = 6'd0; nn_i = 6'd4; ll_i = 64'd5;
      run_block("clean", 1'b1, 1'b1, 64'd5);
      read_hash("clean", 4);
      check("clean_err", err_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/blake2_block_ctrl.md
Name: blake2_block_ctrl

Overview:
- Sequences the BLAKE2s compression core from the byte stream produced by the I/O interface.
- Counts the bytes of each 64-byte block and maintains the 64-bit byte offset t.
- Issues one start pulse per completed block, with first/last/t qualifiers, then waits for the core to finish.
- After the final block, streams the digest bytes out to the pads.
- Sits between the I/O interface (data/config side) and the compression core plus its block/state memory.

Parameters:
- BLOCK_BYTES, 64, bytes per message block; data_idx_i width is log2(BLOCK_BYTES).
- HASH_BYTES_MAX, 32, maximum digest length in bytes; larger nn values are clamped to this.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- kk_i  in  6  key length in bytes (from config)
- nn_i  in  6  digest length in bytes (from config)
- ll_i  in  64  message length in bytes (from config)
- data_v_i  in  1  data byte valid
- data_idx_i  in  6  byte index within the current block
- block_first_i  in  1  current block is the first of the message
- block_last_i  in  1  current block is the last of the message
- cmp_start_o  out  1  one-cycle pulse: start compression of the buffered block
- cmp_first_o  out  1  init h from the parameter block; held while busy
- cmp_last_o  out  1  set finalization flag f0; held while busy
- cmp_t_o  out  64  byte offset t for this compression; held while busy
- cmp_done_i  in  1  one-cycle pulse from the core: compression finished
- hash_rd_o  out  1  read strobe into the digest memory
- hash_idx_o  out  5  digest byte address
- hash_v_o  out  1  digest byte valid on the core-side hash bus (one cycle after hash_rd_o)
- ready_v_o  out  1  controller can accept data bytes
- err_o  out  1  sticky protocol error

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: state=IDLE; t=0; all outputs 0 except ready_v_o=1. Reset mid-operation aborts any compression or readout immediately, with no further cmp_start_o or hash_rd_o.
- States: IDLE, FILL, START, BUSY, OUT.
- IDLE/FILL, ready_v_o=1:
  - A data_v_i byte with data_idx_i==0 in IDLE moves to FILL.
  - A data_v_i byte with data_idx_i==BLOCK_BYTES-1 latches block_first_i and block_last_i, computes t, and moves to START. This applies in IDLE too.
- t computation, 64-bit, wraps mod 2^64:
  - first block: t_base = 0.
  - otherwise: t_base = previous t.
  - non-last block: t = t_base + 64.
  - last block: t = ll_i + (kk_i != 0 ? 64 : 0). A key-only message with ll_i=0 and kk_i≠0 gives t=64.
- START, lasts one cycle: cmp_start_o=1; cmp_first_o, cmp_last_o and cmp_t_o valid; ready_v_o=0. Next state is BUSY. Latency is one cycle from the byte-63 input to cmp_start_o.
- BUSY: cmp_first_o, cmp_last_o and cmp_t_o held stable; ready_v_o=0.
  - On cmp_done_i: go to OUT if the block was last, else to FILL.
  - ready_v_o rises the cycle after cmp_done_i.
- OUT: streams n = min(nn_i, HASH_BYTES_MAX) bytes.
  - hash_rd_o=1 with hash_idx_o = 0..n-1 on consecutive cycles.
  - hash_v_o is hash_rd_o delayed by one cycle.
  - After idx n-1 is issued, go to IDLE; t is cleared on this transition.
  - nn_i==0 → no reads; OUT exits to IDLE after one cycle with hash_v_o never asserted.
- Error handling:
  - data_v_i while ready_v_o=0 sets err_o, and the byte is ignored.
  - cmp_done_i outside BUSY sets err_o, and is ignored.
  - In FILL, a data_idx_i that is not the previous index + 1 sets err_o; counting resyncs to the received index.
  - err_o clears only on reset.
- Simultaneous events:
  - cmp_done_i and data_v_i in the same BUSY cycle: the done is honoured and the byte flags an error.
  - block_first_i and block_last_i both high on one block: cmp_first_o=1, cmp_last_o=1, t from the last-block rule.
- Config sampling: kk_i, nn_i and ll_i are sampled only at the byte-63 transition (kk_i, ll_i) and on OUT entry (nn_i). Config changes mid-block do not affect the current block.

Test Plan:
- Single block: kk=0, nn=32, ll=3; 64 bytes with first=last=1 → cmp_start_o 1 cycle after idx 63, first=1, last=1, t=3; done after 10 cycles → hash_rd idx 0..31 on consecutive cycles, hash_v_o lagging by 1; ready_v_o returns after idx 31.
- Three blocks: ll=150, kk=0 → t = 64, 128, 150; first only on block 0, last only on block 2; ready_v_o low from START through done on each block.
- Keyed: kk=16, ll=0; one key block with first=last=1 → t=64. Keyed with ll=100: key block t=64 (non-last), then data blocks t=128, then final t=164.
- nn=40 → exactly 32 hash reads; nn=0 → no hash_v_o, returns to IDLE.
- Protocol errors: byte during BUSY → err_o=1, no change to t or cmp_start_o; index jump 5→7 in FILL → err_o=1.
- Reset asserted in BUSY and in OUT (idx 10) → next cycle state IDLE, ready_v_o=1, hash_rd_o=0, t=0; a following clean single-block message produces correct t.
